// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues one fetch at a time, hands words to IF/ID,
// and applies EX redirects, holding a stalled word or a redirect that arrives mid-fetch.
module fetch_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] buf_word;
  logic        redir_bad;
  logic        deliver;
  logic [31:0] deliver_word;
  logic        capture;
  logic        pend_set;
  logic        pend_clr;

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A misaligned redirect beats everything, then redirects beat stall.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = redir_bad ? HALT : REQ;
      REQ: begin
        if (redir_bad)           state_nxt = HALT;
        else if (redirect_valid) state_nxt = REQ;
        else                     state_nxt = WAIT;
      end
      WAIT: begin
        if (redir_bad) state_nxt = HALT;
        else if (imem_rvalid) begin
          if (redirect_valid || pend_valid) state_nxt = REQ;
          else if (stall)                   state_nxt = HOLD;
          else                              state_nxt = REQ;
        end
      end
      HOLD: begin
        if (redir_bad)           state_nxt = HALT;
        else if (redirect_valid) state_nxt = REQ;
        else if (!stall)         state_nxt = REQ;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    next_pc      = pc_cur;
    deliver      = 1'b0;
    deliver_word = buf_word;
    capture      = 1'b0;
    pend_set     = 1'b0;
    pend_clr     = 1'b0;
    unique case (state)
      IDLE, REQ: begin
        if (redirect_valid && !redir_bad) next_pc = redirect_pc;
      end
      WAIT: begin
        if (!redir_bad) begin
          if (imem_rvalid) begin
            pend_clr = 1'b1;
            // A fresh redirect in the response cycle supersedes any pending one.
            if (redirect_valid)  next_pc = redirect_pc;
            else if (pend_valid) next_pc = pend_pc;
            else if (!stall) begin
              deliver      = 1'b1;
              deliver_word = imem_rdata;
              next_pc      = pc_cur + 32'd4;
            end else begin
              capture = 1'b1;
            end
          end else if (redirect_valid) begin
            pend_set = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!redir_bad) begin
          if (redirect_valid) next_pc = redirect_pc;
          else if (!stall) begin
            deliver = 1'b1;
            next_pc = pc_cur + 32'd4;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req       <= 1'b0;
      imem_addr      <= '0;
      if_valid       <= 1'b0;
      if_instr       <= NOP_INSTR;
      if_pc          <= '0;
      fetch_misalign <= 1'b0;
      pend_valid     <= 1'b0;
      pend_pc        <= '0;
      buf_word       <= '0;
    end else begin
      // next_pc is what the PC register will hold during the REQ cycle.
      imem_req <= (state_nxt == REQ);
      if (state_nxt == REQ) imem_addr <= next_pc;
      if_valid <= deliver;
      if (deliver) begin
        if_instr <= deliver_word;
        if_pc    <= pc_cur;
      end
      if (capture) buf_word <= imem_rdata;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (state_nxt == HALT) fetch_misalign <= 1'b1;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: NOP_INSTR, default 32'h0000_0013, value driven on if_instr when no instruction has been delivered.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_cur  input  32  current PC, from PC register output.
REQ-005 next_pc  output  32  combinational next value for the PC register; equals pc_cur to hold.
REQ-006 redirect_valid  input  1  one-cycle pulse from EX: taken branch or jump.
REQ-007 redirect_pc  input  32  redirect target, sampled when redirect_valid=1.
REQ-008 stall  input  1  hazard-unit stall; decode cannot accept an instruction.
REQ-009 imem_req  output  1  one-cycle fetch request pulse, registered.
REQ-010 imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-011 imem_rvalid  input  1  instruction-memory response strobe; arrives 1 or more cycles after imem_req.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-013 if_valid  output  1  registered one-cycle pulse: if_instr/if_pc hold a new instruction for IF/ID.
REQ-014 if_instr  output  32  delivered instruction; holds last value between pulses.
REQ-015 if_pc  output  32  PC of delivered instruction.
REQ-016 fetch_misalign  output  1  sticky misaligned-redirect error flag.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD and HALT.
REQ-018 IDLE SHALL go to REQ unconditionally one cycle after reset deasserts; next_pc=pc_cur.
REQ-019 REQ SHALL assert imem_req with imem_addr=pc_cur for exactly one cycle, then go to WAIT; next_pc=pc_cur.
REQ-020 WAIT without imem_rvalid SHALL stay in WAIT with next_pc=pc_cur.
REQ-021 WAIT with imem_rvalid, stall=0, no redirect pending SHALL register if_instr=imem_rdata, if_pc=pc_cur and if_valid=1 at the next edge; next_pc=pc_cur+4; go to REQ.
REQ-022 WAIT with imem_rvalid and stall=1 SHALL capture imem_rdata into a one-entry buffer, go to HOLD, and keep next_pc=pc_cur.
REQ-023 HOLD SHALL wait while stall=1; when stall=0 it SHALL deliver the buffered word as in REQ-021 (next_pc=pc_cur+4, go to REQ).
REQ-024 pc_cur+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 redirect_valid in IDLE, REQ or HOLD SHALL set next_pc=redirect_pc, discard any buffered word without if_valid, and go to REQ.
REQ-026 redirect_valid in WAIT without imem_rvalid SHALL store redirect_pc as pending and stay in WAIT; a later redirect SHALL overwrite the pending target.
REQ-027 imem_rvalid in WAIT with a pending redirect, or in the same cycle as redirect_valid, SHALL discard the response (no if_valid), set next_pc=target, clear pending, and go to REQ.
REQ-028 Redirect SHALL take priority over stall in every state.
REQ-029 redirect_valid with redirect_pc[1:0]!=0 SHALL set fetch_misalign=1, go to HALT, and leave the PC unchanged.
REQ-030 HALT SHALL keep imem_req=0, if_valid=0, next_pc=pc_cur until reset.
REQ-031 imem_rvalid outside WAIT SHALL be ignored.
REQ-032 No more than one fetch SHALL be outstanding; each fetch SHALL take at least 2 cycles.

Reset
REQ-033 On reset assertion, mid-operation included: state=IDLE; imem_req=0, imem_addr=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, fetch_misalign=0; pending redirect and buffer cleared; a response still in flight SHALL be ignored.

Verification
REQ-034 Reset release with 1-cycle memory latency and stall=0 -> imem_addr 0x0, 0x4, 0x8 on alternate cycles; if_valid pulses with if_pc 0x0, 0x4, 0x8.
REQ-035 rvalid with rdata 32'h0050_0093 while stall=1; stall drops 3 cycles later -> no if_valid during stall; then one if_valid with that word; next imem_addr=pc_cur+4.
REQ-036 redirect 0x100 in WAIT, rvalid 2 cycles later -> response discarded (no if_valid); next imem_addr=0x100.
REQ-037 redirect 0x200 in the same cycle as rvalid -> no if_valid; next_pc=0x200; next imem_addr=0x200.
REQ-038 redirect 0x102 -> fetch_misalign=1; imem_req stays 0 and PC frozen until reset; reset clears the flag.
REQ-039 Delivery at pc_cur=0xFFFF_FFFC -> next_pc=0x0000_0000.
